// File: rtl/riscv_pkg.sv
// RV32I definitions shared by the immediate extender, the decoder and the instruction packer.
package riscv_pkg;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immsrc_t;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   // Register/funct fields in their instr[24:7] order.
   typedef struct packed {
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
   } reg_fields_t;

   // True when v survives truncation to a bits-wide two's-complement value.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] t;
      t = $signed(v) >>> (bits - 1);
      return (t == '0) || (t == '1);
   endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Request/response bundle of the instruction packer; master drives requests and consumes words.
interface instr_packer_if #(
   parameter int ADDR_W = 32
);
   logic                in_valid;
   logic                in_ready;
   riscv_pkg::immsrc_t  in_immsrc;
   logic [31:0]         in_imm;
   logic [6:0]          in_opcode;
   logic [2:0]          in_funct3;
   logic [6:0]          in_funct7;
   logic [4:0]          in_rd;
   logic [4:0]          in_rs1;
   logic [4:0]          in_rs2;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_instr;
   logic [ADDR_W-1:0]   out_addr;
   logic                out_err;

   modport master (
      output in_valid, in_immsrc, in_imm, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err
   );

   modport slave (
      input  in_valid, in_immsrc, in_imm, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err
   );
endinterface

// File: rtl/instr_packer_imm_pack.sv
// Combinational immediate scatter into instr[31:7] plus the mask of register/funct3 slots.
// range_err exists only when IMM_CHECK_EN is defined; otherwise it is tied low.
module imm_pack
   import riscv_pkg::*;
(
   input  immsrc_t     immsrc,
   input  logic [31:0] imm,
   output logic [31:7] imm_bits,
   output logic [31:7] fld_mask,
   output logic        range_err
);

   always_comb begin
      imm_bits = '0;
      fld_mask = '0;
      case (immsrc)
         IMM_I: begin
            imm_bits = {imm[11:0], 13'b0};
            fld_mask = {12'h000, 13'h1FFF};
         end
         IMM_S: begin
            imm_bits = {imm[11:5], 13'b0, imm[4:0]};
            fld_mask = {7'h00, 5'h1F, 5'h1F, 3'h7, 5'h00};
         end
         IMM_B: begin
            imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11]};
            fld_mask = {7'h00, 5'h1F, 5'h1F, 3'h7, 5'h00};
         end
         IMM_J: begin
            imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 5'b0};
            fld_mask = {20'h00000, 5'h1F};
         end
         default: begin
            imm_bits = '0;
            fld_mask = '0;
         end
      endcase
   end

`ifdef IMM_CHECK_EN
   always_comb begin
      range_err = 1'b0;
      case (immsrc)
         IMM_I, IMM_S: range_err = !fits_signed(imm, 12);
         IMM_B:        range_err = !fits_signed(imm, 13) || imm[0];
         IMM_J:        range_err = !fits_signed(imm, 21) || imm[0];
         default:      range_err = 1'b0;
      endcase
   end
`else
   logic unused_imm;
   assign unused_imm = ^imm[31:21];
   assign range_err  = 1'b0;
`endif

endmodule

// File: rtl/instr_packer.sv
// Packs immediate + fields into RV32I words with sequential byte addresses; one register stage, latency 1.
// in_ready = !out_valid || out_ready (full throughput, word held under backpressure); IMM_CHECK_EN adds out_err/err_cnt.
module instr_packer
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_base,
   instr_packer_if.slave     bus,
   output logic [CNT_W-1:0]  err_cnt
);

   logic [31:7]       imm_bits;
   logic [31:7]       fld_mask;
   logic              range_err;
   reg_fields_t       fld;
   logic [31:0]       packed_word;
   logic              ready_c;
   logic              accept;
   logic              xfer;
   logic              vld_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] addr_q;

   imm_pack u_imm_pack (
      .immsrc    (bus.in_immsrc),
      .imm       (bus.in_imm),
      .imm_bits  (imm_bits),
      .fld_mask  (fld_mask),
      .range_err (range_err)
   );

   assign fld = '{rs2: bus.in_rs2, rs1: bus.in_rs1, funct3: bus.in_funct3, rd: bus.in_rd};
   // Fields a format does not carry are masked out, so stray inputs cannot corrupt the word.
   assign packed_word = {imm_bits | ({7'b0, fld} & fld_mask), bus.in_opcode};

   assign ready_c = !vld_q || bus.out_ready;
   assign accept  = bus.in_valid && ready_c;
   assign xfer    = vld_q && bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q   <= 1'b0;
         instr_q <= '0;
      end else if (accept) begin
         vld_q   <= 1'b1;
         instr_q <= packed_word;
      end else if (xfer) begin
         vld_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         addr_q <= '0;
      else if (addr_load)
         addr_q <= {addr_base[ADDR_W-1:2], 2'b00};
      else if (xfer)
         addr_q <= addr_q + ADDR_W'(4);
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = vld_q;
   assign bus.out_instr = instr_q;
   assign bus.out_addr  = addr_q;

`ifdef IMM_CHECK_EN
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= 1'b0;
      else if (accept)
         err_q <= range_err;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (xfer && err_q && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.out_err = err_q;
   assign err_cnt     = cnt_q;
`else
   logic unused_err;
   assign unused_err  = range_err;
   assign bus.out_err = 1'b0;
   assign err_cnt     = '0;
`endif

   logic unused_in;
   assign unused_in = ^{addr_base[1:0], bus.in_funct7};

endmodule

// File: tb/tb_instr_packer.sv
// Bench for instr_packer: directed vector table, handshake corner sequences and a random scoreboard run.
module tb_instr_packer;
   import riscv_pkg::*;

`ifdef IMM_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int N_RND = 10000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        addr_load = 1'b0;
   logic [31:0] addr_base = '0;
   logic [15:0] err_cnt;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   instr_packer_if #(.ADDR_W(32)) bus ();

   instr_packer #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr_load (addr_load),
      .addr_base (addr_base),
      .bus       (bus),
      .err_cnt   (err_cnt)
   );

   typedef struct {
      immsrc_t     src;
      logic [31:0] imm;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] ins;
      logic [31:0] addr;
      logic        err;
      logic [15:0] cnt;
   } vec_t;

   typedef struct {
      immsrc_t     src;
      logic [31:0] imm;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        err;
   } exp_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Immediate extender: what a decoder recovers from the packed word.
   function automatic logic [31:0] ext(input logic [31:0] i, input immsrc_t src);
      case (src)
         IMM_I:   return {{20{i[31]}}, i[31:20]};
         IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   // Value the word can carry: sign truncation to the format width, odd offsets rounded down.
   function automatic logic [31:0] trunc(input logic [31:0] imm, input immsrc_t src);
      int s = imm;
      case (src)
         IMM_I, IMM_S: return 32'((s <<< 20) >>> 20);
         IMM_B:        return 32'(((s <<< 19) >>> 19) & -2);
         default:      return 32'(((s <<< 11) >>> 11) & -2);
      endcase
   endfunction

   function automatic logic repr(input logic [31:0] imm, input immsrc_t src);
      int s = imm;
      case (src)
         IMM_I, IMM_S: return (s >= -2048) && (s <= 2047);
         IMM_B:        return (s >= -4096) && (s <= 4095) && ((s & 1) == 0);
         default:      return (s >= -(1 << 20)) && (s < (1 << 20)) && ((s & 1) == 0);
      endcase
   endfunction

   // Non-immediate fields a format carries; absent ones read as zero.
   function automatic logic [24:0] flds(input immsrc_t src, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      logic has_rd, has_f3, has_rs1, has_rs2;
      has_rd  = (src == IMM_I) || (src == IMM_J);
      has_f3  = (src != IMM_J);
      has_rs1 = (src != IMM_J);
      has_rs2 = (src == IMM_S) || (src == IMM_B);
      return {op, has_f3 ? f3 : 3'd0, has_rd ? rd : 5'd0, has_rs1 ? rs1 : 5'd0, has_rs2 ? rs2 : 5'd0};
   endfunction

   task automatic drive(input immsrc_t src, input logic [31:0] imm, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2);
      bus.in_immsrc = src;
      bus.in_imm    = imm;
      bus.in_opcode = op;
      bus.in_funct3 = f3;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct7 = 7'($urandom);
   endtask

   vec_t        tbl[6];
   exp_t        q[$];
   exp_t        e;
   logic [31:0] exp_addr;
   logic [15:0] model_cnt;
   int          sent;
   int          cyc;

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(IMM_I, '0, '0, '0, '0, '0, '0);

      tbl[0] = '{IMM_I, 32'hFFFF_FFFF, OP_IMM,    3'd0, 5'd5, 5'd0, 5'd0, 32'hFFF0_0293, 32'h00, 1'b0, 16'd0};
      tbl[1] = '{IMM_S, 32'h0000_0008, OP_STORE,  3'd2, 5'd0, 5'd1, 5'd2, 32'h0020_A423, 32'h04, 1'b0, 16'd0};
      tbl[2] = '{IMM_B, 32'hFFFF_FFFC, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFE00_0EE3, 32'h08, 1'b0, 16'd0};
      tbl[3] = '{IMM_J, 32'h0000_0800, OP_JAL,    3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_00EF, 32'h0C, 1'b0, 16'd0};
      tbl[4] = '{IMM_B, 32'h0000_0003, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0163, 32'h10, CHK,
                 CHK ? 16'd1 : 16'd0};
      tbl[5] = '{IMM_I, 32'h0000_0800, OP_IMM,    3'd0, 5'd0, 5'd0, 5'd0, 32'h8000_0013, 32'h14, CHK,
                 CHK ? 16'd2 : 16'd0};

      #12;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_instr", bus.out_instr, 32'h0);
      check("rst_out_addr",  bus.out_addr,  32'h0);
      check("rst_out_err",   bus.out_err,   1'b0);
      check("rst_err_cnt",   err_cnt,       16'h0);
      check("rst_in_ready",  bus.in_ready,  1'b1);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(tbl[i].src, tbl[i].imm, tbl[i].op, tbl[i].f3, tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
         check($sformatf("vec%0d_instr", i), bus.out_instr, tbl[i].ins);
         check($sformatf("vec%0d_addr", i),  bus.out_addr,  tbl[i].addr);
         check($sformatf("vec%0d_err", i),   bus.out_err,   tbl[i].err);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_cnt", i),   err_cnt,       tbl[i].cnt);
      end

      // Backpressure: word held for three cycles while a different request waits.
      @(negedge clk);
      drive(IMM_I, 32'h5, OP_IMM, 3'd0, 5'd3, 5'd4, 5'd0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      drive(IMM_S, 32'h7FF, OP_STORE, 3'd2, 5'd9, 5'd9, 5'd9);
      for (int k = 0; k < 3; k++) begin
         check("bp_in_ready", bus.in_ready,  1'b0);
         check("bp_valid",    bus.out_valid, 1'b1);
         check("bp_instr",    bus.out_instr, 32'h0052_0193);
         check("bp_addr",     bus.out_addr,  32'h18);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_valid", bus.out_valid, 1'b0);
      check("bp_rel_addr",  bus.out_addr,  32'h1C);

      // addr_load coinciding with a transfer takes precedence over the increment.
      @(negedge clk);
      drive(IMM_J, 32'h800, OP_JAL, 3'd0, 5'd1, 5'd0, 5'd0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("ld_pre_addr", bus.out_addr, 32'h1C);
      @(negedge clk);
      addr_load = 1'b1;
      addr_base = 32'h1003;
      @(posedge clk);
      #1;
      addr_load = 1'b0;
      check("ld_addr",  bus.out_addr,  32'h1000);
      check("ld_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      drive(IMM_I, 32'h1, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("ld_word_addr", bus.out_addr, 32'h1000);
      @(posedge clk);
      #1;
      check("ld_next_addr", bus.out_addr, 32'h1004);

      // Reset while a word is held drops it at once.
      @(negedge clk);
      drive(IMM_S, 32'h10, OP_STORE, 3'd2, 5'd0, 5'd3, 5'd4);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("mid_valid", bus.out_valid, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_valid", bus.out_valid, 1'b0);
      check("mid_rst_instr", bus.out_instr, 32'h0);
      check("mid_rst_addr",  bus.out_addr,  32'h0);
      check("mid_rst_cnt",   err_cnt,       16'h0);
      @(negedge clk);
      reset = 1'b1;

      // Random stream against the scoreboard.
      exp_addr  = '0;
      model_cnt = '0;
      sent      = 0;
      cyc       = 0;
      while ((sent < N_RND) && (cyc < 40000)) begin
         @(negedge clk);
         cyc++;
         begin
            logic [31:0] imm;
            imm = 32'($signed($urandom) >>> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
            drive(immsrc_t'($urandom_range(0, 3)), imm, 7'($urandom), 3'($urandom),
                  5'($urandom), 5'($urandom), 5'($urandom));
         end
         bus.in_valid  = ($urandom_range(0, 4) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         check("hs_valid", bus.out_valid, q.size() != 0);
         check("hs_ready", bus.in_ready,  (q.size() == 0) || bus.out_ready);
         if (bus.out_valid && bus.out_ready && (q.size() != 0)) begin
            e = q.pop_front();
            check("rnd_imm",  ext(bus.out_instr, e.src), trunc(e.imm, e.src));
            check("rnd_fld",  flds(e.src, bus.out_instr[6:0], bus.out_instr[14:12], bus.out_instr[11:7],
                                   bus.out_instr[19:15], bus.out_instr[24:20]),
                              flds(e.src, e.op, e.f3, e.rd, e.rs1, e.rs2));
            check("rnd_addr", bus.out_addr, exp_addr);
            check("rnd_err",  bus.out_err,  e.err);
            exp_addr = exp_addr + 32'd4;
            if (e.err && (model_cnt != 16'hFFFF)) model_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back('{bus.in_immsrc, bus.in_imm, bus.in_opcode, bus.in_funct3, bus.in_rd,
                          bus.in_rs1, bus.in_rs2, CHK && !repr(bus.in_imm, bus.in_immsrc)});
            sent++;
         end
      end
      check("rnd_sent", sent, N_RND);

      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         #1;
         if (bus.out_valid && (q.size() != 0)) begin
            e = q.pop_front();
            check("drain_imm",  ext(bus.out_instr, e.src), trunc(e.imm, e.src));
            check("drain_addr", bus.out_addr, exp_addr);
            check("drain_err",  bus.out_err,  e.err);
            exp_addr = exp_addr + 32'd4;
            if (e.err && (model_cnt != 16'hFFFF)) model_cnt++;
         end
      end
      @(posedge clk);
      #1;
      check("drain_empty",   q.size(),      0);
      check("drain_valid",   bus.out_valid, 1'b0);
      check("final_err_cnt", err_cnt,       model_cnt);
      check("final_addr",    bus.out_addr,  exp_addr);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
